// File: rtl/dds_meas_pkg.sv
// Shared types for the DDS frequency meter: FSM states, result record and
// the saturating all-ones helper used for the period counter width.
package dds_meas_pkg;

  typedef enum logic [1:0] {SYNC, ARM, MEASURE, HOLD} meas_state_t;

  localparam int unsigned RES_PERIOD_W = 64;
  localparam int unsigned RES_SAMPLE_W = 32;

  // Widest supported field sizes; the meter narrows them at its ports.
  typedef struct packed {
    logic [RES_PERIOD_W-1:0]        period;
    logic                           timeout;
    logic signed [RES_SAMPLE_W-1:0] pmax;
    logic signed [RES_SAMPLE_W-1:0] pmin;
  } meas_result_t;

  function automatic logic [RES_PERIOD_W-1:0] sat_all_ones(input int unsigned width);
    if (width >= RES_PERIOD_W) return '1;
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/zero_cross_det.sv
// Hysteresis comparator: tracks the sign state of the sample stream and flags
// a rising zero crossing on the sample that first reaches +HYST from below.
module zero_cross_det #(
  parameter int unsigned IN_W = 14,
  parameter int unsigned HYST = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] sample_in,
  input  logic                   sample_valid,
  output logic                   pos,
  output logic                   pos_known,
  output logic                   rise
);

  localparam logic signed [IN_W-1:0] HI_TH = IN_W'(HYST);
  localparam logic signed [IN_W-1:0] LO_TH = -HI_TH;

  logic above, below;

  always_comb begin
    above = (sample_in >= HI_TH);
    below = (sample_in <= LO_TH);
    rise  = sample_valid && pos_known && !pos && above;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos       <= 1'b0;
      pos_known <= 1'b0;
    end else if (sample_valid) begin
      if (above) begin
        pos       <= 1'b1;
        pos_known <= 1'b1;
      end else if (below) begin
        pos       <= 1'b0;
        pos_known <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dds_freq_meter.sv
// Period meter: counts accepted samples across 2^AVG_LOG2 rising crossings.
// Peak max/min tracking is built only when FREQ_METER_PEAK_EN is defined.
module dds_freq_meter
  import dds_meas_pkg::*;
#(
  parameter int unsigned IN_W      = 14,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned AVG_LOG2  = 2,
  parameter int unsigned HYST      = 64,
  parameter int unsigned TIMEOUT_W = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] sample_in,
  input  logic                   sample_valid,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [CNT_W-1:0]       period_cycles,
  output logic                   meas_timeout,
  output logic signed [IN_W-1:0] peak_max,
  output logic signed [IN_W-1:0] peak_min,
  output logic                   busy
);

  localparam int unsigned XW = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(sat_all_ones(CNT_W));
  localparam logic [XW-1:0]    X_ONE    = XW'(1);
  localparam logic [XW-1:0]    X_TARGET = XW'(1 << AVG_LOG2);

  meas_state_t            state;
  meas_result_t           res;
  logic [CNT_W-1:0]       count, count_inc;
  logic [XW-1:0]          crossings, crossings_inc;
  logic [TIMEOUT_W-1:0]   tmo, tmo_inc;
  logic                   pos_known, rise, done, expired;
  logic                   unused_pos, unused_res;

  zero_cross_det #(.IN_W(IN_W), .HYST(HYST)) u_zcd (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .pos          (unused_pos),
    .pos_known    (pos_known),
    .rise         (rise)
  );

  always_comb begin
    count_inc     = (count == CNT_MAX) ? count : count + CNT_W'(1);
    tmo_inc       = tmo + TIMEOUT_W'(1);
    crossings_inc = crossings + X_ONE;
    done          = rise && (crossings_inc == X_TARGET);
    expired       = (tmo_inc == '1);
  end

`ifdef FREQ_METER_PEAK_EN
  logic signed [IN_W-1:0] pmax_q, pmin_q, pmax_n, pmin_n;

  always_comb begin
    pmax_n = (sample_in > pmax_q) ? sample_in : pmax_q;
    pmin_n = (sample_in < pmin_q) ? sample_in : pmin_q;
  end

  assign peak_max = res.pmax[IN_W-1:0];
  assign peak_min = res.pmin[IN_W-1:0];
`else
  assign peak_max = '0;
  assign peak_min = '0;
`endif

  assign period_cycles = res.period[CNT_W-1:0];
  assign meas_timeout  = res.timeout;
  assign unused_res    = ^{res.period, res.pmax, res.pmin};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SYNC;
      res          <= '0;
      count        <= '0;
      crossings    <= '0;
      tmo          <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
`ifdef FREQ_METER_PEAK_EN
      pmax_q       <= '0;
      pmin_q       <= '0;
`endif
    end else begin
      case (state)
        SYNC: if (pos_known) begin
          state <= ARM;
          busy  <= 1'b1;
        end
        ARM: if (rise) begin
          count     <= '0;
          crossings <= '0;
          tmo       <= '0;
          state     <= MEASURE;
`ifdef FREQ_METER_PEAK_EN
          pmax_q    <= sample_in;
          pmin_q    <= sample_in;
`endif
        end
        MEASURE: if (sample_valid) begin
          count <= count_inc;
          tmo   <= tmo_inc;
          if (rise) crossings <= crossings_inc;
`ifdef FREQ_METER_PEAK_EN
          pmax_q <= pmax_n;
          pmin_q <= pmin_n;
          res.pmax <= RES_SAMPLE_W'(pmax_n);
          res.pmin <= RES_SAMPLE_W'(pmin_n);
`endif
          // Completion is tested first so it wins over a same-cycle timeout.
          if (done || expired) begin
            res.period   <= done ? RES_PERIOD_W'(count_inc) : RES_PERIOD_W'(CNT_MAX);
            res.timeout  <= !done;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= HOLD;
          end
        end
        HOLD: if (result_valid && result_ready) begin
          result_valid <= 1'b0;
          busy         <= 1'b1;
          state        <= ARM;
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_freq_meter.sv
// Directed bench for dds_freq_meter: square, gapped and noisy sine periods,
// result hold/handshake, mid-measurement reset and timeout (TIMEOUT_W=8 copy).
module tb_dds_freq_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic signed [13:0] sample_in;
  logic               sample_valid;
  logic               result_ready;

  logic               rv, mt, busy;
  logic [31:0]        pc;
  logic signed [13:0] pmx, pmn;
  logic               rv_to, mt_to, busy_to;
  logic [31:0]        pc_to;
  logic signed [13:0] pmx_to, pmn_to;

  int checks = 0;
  int errors = 0;
  int n, sent;
  logic [31:0] held_pc;
  logic        hold_ok;

  dds_freq_meter dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .result_valid(rv), .result_ready(result_ready), .period_cycles(pc),
    .meas_timeout(mt), .peak_max(pmx), .peak_min(pmn), .busy(busy)
  );

  dds_freq_meter #(.TIMEOUT_W(8)) dut_to (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .result_valid(rv_to), .result_ready(result_ready), .period_cycles(pc_to),
    .meas_timeout(mt_to), .peak_max(pmx_to), .peak_min(pmn_to), .busy(busy_to)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [13:0] sq(input int idx);
    return ((idx % 100) < 50) ? -14'sd8192 : 14'sd8191;
  endfunction

  function automatic logic signed [13:0] sine(input int idx);
    int s;
    s = $rtoi(8000.0 * $sin(2.0 * 3.14159265358979 * idx / 256.0));
    if (s < 200 && s > -200) s = s + int'($urandom_range(100)) - 50;
    return 14'(s);
  endfunction

  task automatic step(input logic signed [13:0] s, input logic v);
    sample_in    = s;
    sample_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic run_square(input int max_n, output int cnt);
    cnt = 0;
    while (!rv && cnt < max_n) begin
      step(sq(n), 1'b1);
      n++;
      cnt++;
    end
  endtask

  task automatic consume();
    result_ready = 1'b1;
    step(14'sd0, 1'b0);
    result_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sample_in = '0; sample_valid = 1'b0; result_ready = 1'b0; n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rv, 0);
    check("rst_period", pc, 0);
    check("rst_timeout", mt, 0);
    check("rst_pmax", pmx, 0);
    check("rst_pmin", pmn, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Square wave, period 100, first rise at sample 50, fourth after it at 450.
    run_square(2000, sent);
    check("sq_valid", rv, 1);
    check("sq_latency", sent, 451);
    check("sq_period", pc, 400);
    check("sq_timeout", mt, 0);
    check("sq_busy", busy, 0);
`ifdef FREQ_METER_PEAK_EN
    check("sq_pmax", 64'(pmx), 64'(8191));
    check("sq_pmin", 64'(pmn), 64'(-8192));
`else
    check("sq_pmax", pmx, 0);
    check("sq_pmin", pmn, 0);
`endif

    // Result held with ready low while crossings keep arriving.
    held_pc = pc;
    hold_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(sq(n), 1'b1);
      n++;
      if (!rv || pc != held_pc) hold_ok = 1'b0;
    end
    check("hold_stable", hold_ok, 1);
    check("hold_period", pc, 400);
    result_ready = 1'b1;
    step(sq(n), 1'b1);
    n++;
    result_ready = 1'b0;
    check("ack_valid", rv, 0);
    check("ack_busy", busy, 1);
    run_square(2000, sent);
    check("sq2_valid", rv, 1);
    check("sq2_period", pc, 400);
    consume();

    // 50% valid; gap cycles carry the opposite sign and must be ignored.
    sent = 0;
    for (int c = 0; c < 4000 && !rv; c++) begin
      if (c % 2 == 0) begin
        step(sq(n), 1'b1);
        n++;
      end else begin
        step((sq(n) > 0) ? -14'sd5000 : 14'sd5000, 1'b0);
      end
    end
    check("gap_valid", rv, 1);
    check("gap_period", pc, 400);
    check("gap_timeout", mt, 0);
    consume();

    // Noisy sine, period 256 samples.
    n = 0;
    while (!rv && n < 3000) begin
      step(sine(n), 1'b1);
      n++;
    end
    check("sine_valid", rv, 1);
    check("sine_period", pc, 1024);
    consume();

    // Reset mid-measurement, then hysteresis boundary on resync.
    run_square(200, sent);
    check("mid_busy", busy, 1);
    check("mid_novalid", rv, 0);
    rst = 1'b1;
    step(14'sd0, 1'b0);
    rst = 1'b0;
    check("mrst_valid", rv, 0);
    check("mrst_period", pc, 0);
    check("mrst_timeout", mt, 0);
    check("mrst_busy", busy, 0);
    for (int i = 0; i < 20; i++) step((i % 2 == 0) ? 14'sd63 : -14'sd63, 1'b1);
    check("sync_hold_busy", busy, 0);
    step(14'sd64, 1'b1);
    check("sync_edge_busy", busy, 0);
    step(14'sd64, 1'b1);
    check("sync_arm_busy", busy, 1);

    // Timeout instance: DC never leaves ARM; one crossing then DC times out.
    rst = 1'b1;
    step(14'sd0, 1'b0);
    rst = 1'b0;
    repeat (600) step(14'sd1000, 1'b1);
    check("dc_novalid", rv_to, 0);
    check("dc_busy", busy_to, 1);
    step(-14'sd64, 1'b1);
    step(14'sd1000, 1'b1);
    sent = 0;
    while (!rv_to && sent < 1000) begin
      step(14'sd1000, 1'b1);
      sent++;
    end
    check("to_valid", rv_to, 1);
    check("to_latency", sent, 255);
    check("to_period", pc_to, 64'hFFFF_FFFF);
    check("to_flag", mt_to, 1);
    check("to_busy", busy_to, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
